// File: rtl/sramlike_arb_pkg.sv
// Shared definitions for the sram-like two-port arbiter: FSM encoding and port ids.
package sramlike_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_INST = 1'b0;
    localparam port_id_t PORT_DATA = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way winner pick: round-robin on ties, or data-first when FIXED_PRIO is set.
module arb_pick2
    import sramlike_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic     inst_req,
    input  logic     data_req,
    input  port_id_t last_grant,
    output port_id_t grant
);

    // Single requester wins outright; a tie goes to data or to the port not served last.
    always_comb begin
        grant = PORT_INST;
        if (inst_req && data_req) begin
            if (FIXED_PRIO != 0) begin
                grant = PORT_DATA;
            end else begin
                grant = (last_grant == PORT_INST) ? PORT_DATA : PORT_INST;
            end
        end else if (data_req) begin
            grant = PORT_DATA;
        end
    end

endmodule

// File: rtl/sramlike_arbiter.sv
// Merges the instruction and data sram-like ports onto one sram-like master,
// with at most one transaction outstanding on the bridge.
module sramlike_arbiter
    import sramlike_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic [31:0] inst_grant_cnt,
    output logic [31:0] data_grant_cnt
);

    arb_state_t  state_q, state_d;
    port_id_t    port_q, port_d;
    port_id_t    last_grant_q, last_grant_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;
    logic [31:0] data_cnt_q, data_cnt_d;
    port_id_t    grant;
    logic        addr_ok_pulse;
    logic        data_ok_pulse;

    arb_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Next-state logic: latch the winner in IDLE, track bridge handshakes in ADDR/DATA.
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        last_grant_d  = last_grant_q;
        wr_d          = wr_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        inst_cnt_d    = inst_cnt_q;
        data_cnt_d    = data_cnt_q;
        addr_ok_pulse = 1'b0;
        data_ok_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    state_d      = ST_ADDR;
                    port_d       = grant;
                    last_grant_d = grant;
                    if (grant == PORT_DATA) begin
                        wr_d       = data_wr;
                        size_d     = data_size;
                        addr_d     = data_addr;
                        wdata_d    = data_wdata;
                        data_cnt_d = data_cnt_q + 32'd1;
                    end else begin
                        wr_d       = inst_wr;
                        size_d     = inst_size;
                        addr_d     = inst_addr;
                        wdata_d    = inst_wdata;
                        inst_cnt_d = inst_cnt_q + 32'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    addr_ok_pulse = 1'b1;
                    if (mem_data_ok) begin
                        data_ok_pulse = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    data_ok_pulse = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request fields and grant counters; reset abandons any transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            port_q       <= PORT_INST;
            last_grant_q <= PORT_INST;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            inst_cnt_q   <= 32'd0;
            data_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_cnt_q   <= inst_cnt_d;
            data_cnt_q   <= data_cnt_d;
        end
    end

    // Bridge-side outputs come from registers only; ok pulses are steered to the granted port.
    assign mem_req        = (state_q == ST_ADDR);
    assign mem_wr         = wr_q;
    assign mem_size       = size_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign inst_addr_ok   = addr_ok_pulse && (port_q == PORT_INST);
    assign data_addr_ok   = addr_ok_pulse && (port_q == PORT_DATA);
    assign inst_data_ok   = data_ok_pulse && (port_q == PORT_INST);
    assign data_data_ok   = data_ok_pulse && (port_q == PORT_DATA);
    assign inst_rdata     = mem_rdata;
    assign data_rdata     = mem_rdata;
    assign inst_grant_cnt = inst_cnt_q;
    assign data_grant_cnt = data_cnt_q;

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed bench: instance dut uses round-robin, instance dut_fp uses fixed data priority.
module tb_sramlike_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    // Round-robin instance signals
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] inst_grant_cnt, data_grant_cnt;

    // Fixed-priority instance signals
    logic        inst_req_b, data_req_b;
    logic [31:0] inst_addr_b, data_addr_b;
    logic [31:0] inst_rdata_b, data_rdata_b;
    logic        inst_addr_ok_b, inst_data_ok_b, data_addr_ok_b, data_data_ok_b;
    logic        mem_req_b, mem_wr_b;
    logic [1:0]  mem_size_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic        mem_addr_ok_b, mem_data_ok_b;
    logic [31:0] inst_grant_cnt_b, data_grant_cnt_b;

    always #5 clk = ~clk;

    sramlike_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt)
    );

    sramlike_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req_b), .inst_wr(1'b0), .inst_size(2'b10),
        .inst_addr(inst_addr_b), .inst_wdata(32'd0), .inst_rdata(inst_rdata_b),
        .inst_addr_ok(inst_addr_ok_b), .inst_data_ok(inst_data_ok_b),
        .data_req(data_req_b), .data_wr(1'b0), .data_size(2'b10),
        .data_addr(data_addr_b), .data_wdata(32'd0), .data_rdata(data_rdata_b),
        .data_addr_ok(data_addr_ok_b), .data_data_ok(data_data_ok_b),
        .mem_req(mem_req_b), .mem_wr(mem_wr_b), .mem_size(mem_size_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok_b), .mem_data_ok(mem_data_ok_b),
        .inst_grant_cnt(inst_grant_cnt_b), .data_grant_cnt(data_grant_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One transaction with same-cycle addr_ok/data_ok. Entered just after a negedge in IDLE
    // with requests already set; returns at the following IDLE negedge with oks cleared.
    task automatic txn(input bit b, input string tag, input logic [31:0] exp_addr, input bit exp_inst);
        @(negedge clk);
        #1;
        chk({tag, " mem_req"}, b ? 32'(mem_req_b) : 32'(mem_req), 32'd1);
        chk({tag, " mem_addr"}, b ? mem_addr_b : mem_addr, exp_addr);
        if (b) begin mem_addr_ok_b = 1'b1; mem_data_ok_b = 1'b1; end
        else   begin mem_addr_ok   = 1'b1; mem_data_ok   = 1'b1; end
        #1;
        chk({tag, " inst_ok"},
            b ? {30'd0, inst_addr_ok_b, inst_data_ok_b} : {30'd0, inst_addr_ok, inst_data_ok},
            exp_inst ? 32'd3 : 32'd0);
        chk({tag, " data_ok"},
            b ? {30'd0, data_addr_ok_b, data_data_ok_b} : {30'd0, data_addr_ok, data_data_ok},
            exp_inst ? 32'd0 : 32'd3);
        @(negedge clk);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_addr_ok_b = 1'b0; mem_data_ok_b = 1'b0;
    endtask

    initial begin
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
        inst_req_b = 0; data_req_b = 0; inst_addr_b = 32'h1000; data_addr_b = 32'h2000;
        mem_addr_ok_b = 0; mem_data_ok_b = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst cnts", inst_grant_cnt | data_grant_cnt, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        resetn = 1'b1;

        // Single read on data port
        @(negedge clk);
        data_req = 1; data_addr = 32'h1FC00010; data_size = 2'b10;
        #1 chk("rd idle mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        data_req = 0; data_addr = 32'h0;
        #1;
        chk("rd mem_req", 32'(mem_req), 32'd1);
        chk("rd mem_addr", mem_addr, 32'h1FC00010);
        chk("rd mem_wr", 32'(mem_wr), 32'd0);
        chk("rd data_cnt", data_grant_cnt, 32'd1);
        mem_addr_ok = 1;
        #1;
        chk("rd data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("rd inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        @(negedge clk);
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd data mem_req", 32'(mem_req), 32'd0);
        chk("rd data_data_ok", 32'(data_data_ok), 32'd1);
        chk("rd data_rdata", data_rdata, 32'hDEADBEEF);
        chk("rd inst_rdata", inst_rdata, 32'hDEADBEEF);
        chk("rd inst_data_ok", 32'(inst_data_ok), 32'd0);
        @(negedge clk);
        mem_data_ok = 0;
        #1 chk("rd back idle", 32'(mem_req), 32'd0);

        // Write with same-cycle addr_ok/data_ok on inst port
        inst_req = 1; inst_wr = 1; inst_size = 2'b10; inst_addr = 32'h100; inst_wdata = 32'h12345678;
        @(negedge clk);
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_wdata = 32'h0;
        #1;
        chk("wr mem_wdata", mem_wdata, 32'h12345678);
        chk("wr mem_wr", 32'(mem_wr), 32'd1);
        chk("wr mem_size", 32'(mem_size), 32'd2);
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("wr inst oks", {30'd0, inst_addr_ok, inst_data_ok}, 32'd3);
        chk("wr data oks", {30'd0, data_addr_ok, data_data_ok}, 32'd0);
        @(negedge clk);
        mem_addr_ok = 0; mem_data_ok = 0;
        #1 chk("wr next idle", 32'(mem_req), 32'd0);
        chk("wr inst_cnt", inst_grant_cnt, 32'd1);

        // Round-robin contention (last grant was inst)
        inst_req = 1; data_req = 1; inst_addr = 32'h1000; data_addr = 32'h2000;
        txn(0, "rr1", 32'h2000, 0);
        txn(0, "rr2", 32'h1000, 1);
        txn(0, "rr3", 32'h2000, 0);
        txn(0, "rr4", 32'h1000, 1);
        inst_req = 0; data_req = 0;
        chk("rr inst_cnt", inst_grant_cnt, 32'd3);
        chk("rr data_cnt", data_grant_cnt, 32'd3);

        // Reset while in DATA
        data_req = 1; data_addr = 32'h3000;
        @(negedge clk);
        data_req = 0; mem_addr_ok = 1;
        @(negedge clk);
        mem_addr_ok = 0;
        #1 chk("mid data mem_req", 32'(mem_req), 32'd0);
        resetn = 0;
        #1;
        chk("mid rst mem_addr", mem_addr, 32'd0);
        chk("mid rst cnts", inst_grant_cnt | data_grant_cnt, 32'd0);
        mem_data_ok = 1;
        #1 chk("mid rst data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
        @(negedge clk);
        resetn = 1;
        #1 chk("stale data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
        @(negedge clk);
        mem_data_ok = 0;
        #1 chk("post rst mem_req", 32'(mem_req), 32'd0);
        inst_req = 1; inst_addr = 32'h4000;
        txn(0, "post rst", 32'h4000, 1);
        inst_req = 0;
        chk("post rst inst_cnt", inst_grant_cnt, 32'd1);

        // Counter wrap on data port
        force dut.data_cnt_q = 32'hFFFFFFFF;
        #1 chk("preset cnt", data_grant_cnt, 32'hFFFFFFFF);
        release dut.data_cnt_q;
        data_req = 1; data_addr = 32'h5000;
        txn(0, "wrap", 32'h5000, 0);
        data_req = 0;
        chk("wrap cnt", data_grant_cnt, 32'd0);

        // Fixed priority: data wins every tie, inst only when data idle
        inst_req_b = 1; data_req_b = 1;
        txn(1, "fp1", 32'h2000, 0);
        txn(1, "fp2", 32'h2000, 0);
        txn(1, "fp3", 32'h2000, 0);
        data_req_b = 0;
        txn(1, "fp4", 32'h1000, 1);
        inst_req_b = 0;
        chk("fp inst_cnt", inst_grant_cnt_b, 32'd1);
        chk("fp data_cnt", data_grant_cnt_b, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sramlike_arbiter.md
SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = data port always wins ties.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inst_req / inst_wr  input  1 each  instruction-cache request / write flag.
REQ-005 inst_size  input  2  inst_addr  input  32  inst_wdata  input  32  instruction-cache request fields.
REQ-006 inst_rdata  output  32  inst_addr_ok  output  1  inst_data_ok  output  1  instruction-cache responses.
REQ-007 data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0]  input  data-cache request fields, same meaning as inst_*.
REQ-008 data_rdata  output  32  data_addr_ok  output  1  data_data_ok  output  1  data-cache responses.
REQ-009 mem_req, mem_wr  output  1 each  mem_size  output  2  mem_addr, mem_wdata  output  32  shared sram-like master toward the AXI bridge.
REQ-010 mem_rdata  input  32  mem_addr_ok, mem_data_ok  input  1 each  bridge responses.
REQ-011 inst_grant_cnt, data_grant_cnt  output  32 each  granted-transaction counters per port.

Function
REQ-012 FSM states: IDLE, ADDR (mem_req asserted, waiting mem_addr_ok), DATA (waiting mem_data_ok); one transaction outstanding at most.
REQ-013 IDLE: if any req high, pick winner, latch its wr/size/addr/wdata and port id into registers, go to ADDR next cycle; otherwise stay in IDLE.
REQ-014 Only one req high: grant that port. Both high with FIXED_PRIO=0: grant the port not granted last. Both high with FIXED_PRIO=1: grant data.
REQ-015 last_grant updates only on an IDLE->ADDR transition.
REQ-016 ADDR: mem_req=1; mem_wr/size/addr/wdata driven from latched registers, not live inputs.
REQ-017 ADDR and mem_addr_ok=1: assert the granted port's *_addr_ok for that cycle; go to DATA, or to IDLE if mem_data_ok is also 1.
REQ-018 DATA: mem_req=0; on mem_data_ok=1, assert the granted port's *_data_ok for that cycle; go to IDLE.
REQ-019 Same-cycle mem_addr_ok and mem_data_ok in ADDR: both the granted port's *_addr_ok and *_data_ok pulse in that cycle.
REQ-020 Non-granted port: *_addr_ok=0 and *_data_ok=0 at all times. inst_rdata and data_rdata both equal mem_rdata (broadcast).
REQ-021 *_addr_ok and *_data_ok are combinational from mem_* and state; mem_* outputs are functions of registers only.
REQ-022 Minimum latency: req seen in IDLE at cycle N, then mem_req at N+1. Back-to-back grants require one IDLE cycle between transactions.
REQ-023 A port whose req drops during ADDR/DATA does not abort the transaction; it completes on the bridge.
REQ-024 Grant counter of the winning port increments by 1 on each IDLE->ADDR transition; 32-bit wrap from 0xFFFFFFFF to 0.
REQ-025 In IDLE, mem_req=0 and all ok outputs are 0.

Reset
REQ-026 resetn low forces immediately: state IDLE, last_grant=inst, latched fields 0, both counters 0, mem_req=0, all *_ok=0.
REQ-027 Reset mid-transaction abandons the transaction; late mem_addr_ok/mem_data_ok arriving in IDLE are ignored.

Structure
REQ-028 State encoding (IDLE/ADDR/DATA) and port ids (PORT_INST=0, PORT_DATA=1) are defined in shared package sramlike_arb_pkg.
REQ-029 The 2-way winner pick (req pair, last_grant, FIXED_PRIO -> grant) is the combinational sub-module arb_pick2; FSM, latches and counters stay in sramlike_arbiter.

Verification
REQ-030 Single read: data_req=1, data_addr=0x1FC00010 -> mem_req at N+1 with mem_addr=0x1FC00010, mem_wr=0; mem_data_ok with mem_rdata=0xDEADBEEF -> data_data_ok=1, data_rdata=0xDEADBEEF, inst_data_ok=0; data_grant_cnt=1.
REQ-031 Contention with FIXED_PRIO=0: inst_req and data_req held high for 4 transactions -> grant order data, inst, data, inst; counters 2/2.
REQ-032 Contention with FIXED_PRIO=1 -> data wins every tie; inst is granted only when data_req=0.
REQ-033 Write with same-cycle addr_ok/data_ok: inst_wr=1, size=2'b10, wdata=0x12345678 -> mem_wdata=0x12345678; both inst_addr_ok and inst_data_ok pulse in one cycle; next state IDLE.
REQ-034 resetn pulled low while in DATA -> all outputs are reset values in the same cycle; a stale mem_data_ok afterward produces no *_data_ok; the next request is arbitrated normally.
REQ-035 Counter preset via force to 0xFFFFFFFF plus one grant -> counter reads 0.
